// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU result path.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALUOP_W   = 3;

  // Bit positions inside the 4-bit flag field {zero, slt, overflow, c_out}
  localparam int FLAG_ZERO = 3;
  localparam int FLAG_SLT  = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_COUT = 0;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [3:0]           flags;
    logic [ALUOP_W-1:0]   aluop;
  } alu_entry_t;

endpackage

// File: rtl/alu_rb_fifo.sv
// Generic synchronous FIFO with registered ready/valid/count and an output
// register. The head is presented from a register, so the output holds the
// last popped value while the FIFO is empty.
module alu_rb_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push_valid,
  output logic          o_push_ready,
  input  logic [DW-1:0] i_push_data,
  output logic          o_pop_valid,
  input  logic          i_pop_ready,
  output logic [DW-1:0] o_pop_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ready;
  logic          r_valid;
  logic [DW-1:0] r_head;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_rd_next;

  assign w_push       = i_push_valid & r_ready;
  assign w_pop        = r_valid & i_pop_ready;
  assign w_rd_next    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign o_push_ready = r_ready;
  assign o_pop_valid  = r_valid;
  assign o_pop_data   = r_head;

  // Occupancy after this edge's push/pop
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_next = r_count - CW'(1);
  end

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers, count and registered handshake flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_ready  <= (w_count_next < DEPTH_C);
      r_valid  <= (w_count_next != '0);
    end
  end

  // Head register: the new head comes straight from the push data when the
  // slot being written is the one that becomes the head, otherwise from memory
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= '0;
    end else if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_next)) r_head <= i_push_data;
      else                                   r_head <= r_mem[w_rd_next];
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Registers ALU results with their flags into a small FIFO, adds a zero flag,
// and tracks sticky overflow status plus a saturating overflow count.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2,
  parameter int OP_W  = ALUOP_W,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_result,
  input  logic             i_in_c_out,
  input  logic             i_in_overflow,
  input  logic             i_in_slt,
  input  logic [OP_W-1:0]  i_in_aluop,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_result,
  output logic [3:0]       o_out_flags,
  output logic [OP_W-1:0]  o_out_aluop,
  input  logic             i_clr_sticky,
  output logic             o_sticky_ovf,
  output logic [CNT_W-1:0] o_ovf_count
);

  localparam int DW = WIDTH + 4 + OP_W;

  logic [3:0]       w_flags;
  logic [DW-1:0]    w_push_data;
  logic [DW-1:0]    w_pop_data;
  logic             w_ovf_push;
  logic             r_sticky_ovf;
  logic [CNT_W-1:0] r_ovf_count;

  // Flag field is built at capture time so the zero flag travels with the entry
  always_comb begin
    w_flags            = '0;
    w_flags[FLAG_ZERO] = (i_in_result == '0);
    w_flags[FLAG_SLT]  = i_in_slt;
    w_flags[FLAG_OVF]  = i_in_overflow;
    w_flags[FLAG_COUT] = i_in_c_out;
  end

  assign w_push_data = {i_in_result, w_flags, i_in_aluop};
  assign w_ovf_push  = i_in_valid & o_in_ready & i_in_overflow;

  alu_rb_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push_valid (i_in_valid),
    .o_push_ready (o_in_ready),
    .i_push_data  (w_push_data),
    .o_pop_valid  (o_out_valid),
    .i_pop_ready  (i_out_ready),
    .o_pop_data   (w_pop_data)
  );

  assign o_out_result = w_pop_data[DW-1 -: WIDTH];
  assign o_out_flags  = w_pop_data[OP_W +: 4];
  assign o_out_aluop  = w_pop_data[OP_W-1:0];

  // Sticky overflow and saturating count; a clear in the same cycle as an
  // overflow push is applied first, so the push is still recorded
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sticky_ovf <= 1'b0;
      r_ovf_count  <= '0;
    end else if (i_clr_sticky) begin
      r_sticky_ovf <= w_ovf_push;
      r_ovf_count  <= w_ovf_push ? CNT_W'(1) : '0;
    end else if (w_ovf_push) begin
      r_sticky_ovf <= 1'b1;
      if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

  assign o_sticky_ovf = r_sticky_ovf;
  assign o_ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [15:0] i_in_result = '0;
  logic        i_in_c_out = 1'b0;
  logic        i_in_overflow = 1'b0;
  logic        i_in_slt = 1'b0;
  logic [2:0]  i_in_aluop = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [15:0] o_out_result;
  logic [3:0]  o_out_flags;
  logic [2:0]  o_out_aluop;
  logic        i_clr_sticky = 1'b0;
  logic        o_sticky_ovf;
  logic [7:0]  o_ovf_count;

  alu_result_buffer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_result(i_in_result), .i_in_c_out(i_in_c_out),
    .i_in_overflow(i_in_overflow), .i_in_slt(i_in_slt), .i_in_aluop(i_in_aluop),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_result(o_out_result), .o_out_flags(o_out_flags), .o_out_aluop(o_out_aluop),
    .i_clr_sticky(i_clr_sticky), .o_sticky_ovf(o_sticky_ovf), .o_ovf_count(o_ovf_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  f;
    logic [2:0]  op;
  } ent_t;

  // Reference model: a queue of entries plus scalar status
  ent_t q[$];
  ent_t m_last;
  bit   m_ready;
  bit   m_sticky;
  int   m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic set_in(input bit v, input logic [15:0] r, input bit c,
                        input bit o, input bit s, input logic [2:0] op);
    i_in_valid = v; i_in_result = r; i_in_c_out = c;
    i_in_overflow = o; i_in_slt = s; i_in_aluop = op;
  endtask

  // One clock: model decides push/pop from its own pre-edge state, then updates
  task automatic tick();
    bit   push, pop;
    ent_t e;
    push = i_in_valid && m_ready;
    pop  = (q.size() > 0) && i_out_ready;
    e.r  = i_in_result;
    e.f  = {(i_in_result == 16'h0), i_in_slt, i_in_overflow, i_in_c_out};
    e.op = i_in_aluop;
    @(posedge i_clk);
    if (i_rst) begin
      q.delete(); m_last = '0; m_ready = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      if (i_clr_sticky) begin m_sticky = 0; m_cnt = 0; end
      if (push && e.f[1]) begin m_sticky = 1; if (m_cnt < 255) m_cnt++; end
      if (pop) m_last = q.pop_front();
      if (push) q.push_back(e);
      m_ready = (q.size() < DEPTH);
    end
    #1;
  endtask

  function automatic ent_t head();
    return (q.size() > 0) ? q[0] : m_last;
  endfunction

  task automatic test_reset();
    i_rst = 1; tick(); tick();
    n_checks++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", o_in_ready); end
    n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", o_out_valid); end
    n_checks++; if ({o_out_result, o_out_flags, o_out_aluop} !== 23'h0) begin n_fail++; $display("FAIL reset_out_data got %h/%b/%b want 0", o_out_result, o_out_flags, o_out_aluop); end
    n_checks++; if ({o_sticky_ovf, o_ovf_count} !== 9'h0) begin n_fail++; $display("FAIL reset_status got %b/%0d want 0/0", o_sticky_ovf, o_ovf_count); end
    i_rst = 0; tick();
    n_checks++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", o_in_ready); end
    n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got %b want 0", o_out_valid); end
  endtask

  task automatic test_single_push();
    set_in(1, 16'h0000, 1, 0, 0, 3'b101); tick(); set_in(0, 0, 0, 0, 0, 0);
    n_checks++; if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", o_out_valid); end
    n_checks++; if (o_out_flags !== 4'b1001) begin n_fail++; $display("FAIL single_flags got %b want 1001", o_out_flags); end
    n_checks++; if (o_out_aluop !== 3'b101) begin n_fail++; $display("FAIL single_aluop got %b want 101", o_out_aluop); end
    i_out_ready = 1; tick(); i_out_ready = 0;
    n_checks++; if (o_out_valid !== 1'b0 || o_out_flags !== 4'b1001) begin n_fail++; $display("FAIL single_drain got v=%b f=%b want v=0 f=1001", o_out_valid, o_out_flags); end
  endtask

  task automatic test_fill();
    i_out_ready = 0;
    set_in(1, 16'h1234, 0, 0, 0, 3'd1); tick();
    set_in(1, 16'h7FFE, 0, 0, 1, 3'd2); tick();
    n_checks++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", o_in_ready); end
    set_in(1, 16'hBEEF, 0, 0, 0, 3'd3); tick(); set_in(0, 0, 0, 0, 0, 0);
    n_checks++; if (o_out_result !== 16'h1234 || o_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold got %h rdy=%b want 1234 rdy=0", o_out_result, o_in_ready); end
    i_out_ready = 1; tick();
    n_checks++; if (o_out_result !== 16'h7FFE || o_out_valid !== 1'b1 || o_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_second got %h v=%b rdy=%b want 7ffe v=1 rdy=1", o_out_result, o_out_valid, o_in_ready); end
    tick();
    n_checks++; if (o_out_valid !== 1'b0 || o_out_result !== 16'h7FFE) begin n_fail++; $display("FAIL fill_empty got v=%b %h want v=0 7ffe", o_out_valid, o_out_result); end
    i_out_ready = 0;
  endtask

  task automatic test_streaming();
    i_out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      set_in(1, 16'(i), 0, 0, 0, 3'(i)); tick();
      n_checks++;
      if (o_out_valid !== 1'b1 || o_out_result !== 16'(i) || o_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d got v=%b %h rdy=%b want v=1 %h rdy=1", i, o_out_valid, o_out_result, o_in_ready, 16'(i));
      end
    end
    set_in(0, 0, 0, 0, 0, 0); tick();
    n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid got %b want 0", o_out_valid); end
  endtask

  task automatic test_overflow();
    i_out_ready = 1;
    for (int i = 0; i < 3; i++) begin set_in(1, 16'h8000, 0, 1, 1, 3'd0); tick(); end
    set_in(0, 0, 0, 0, 0, 0); tick();
    n_checks++; if (o_sticky_ovf !== 1'b1 || o_ovf_count !== 8'd3) begin n_fail++; $display("FAIL ovf_three got %b/%0d want 1/3", o_sticky_ovf, o_ovf_count); end
    i_clr_sticky = 1; tick(); i_clr_sticky = 0;
    n_checks++; if (o_sticky_ovf !== 1'b0 || o_ovf_count !== 8'd0) begin n_fail++; $display("FAIL ovf_clear got %b/%0d want 0/0", o_sticky_ovf, o_ovf_count); end
    i_clr_sticky = 1; set_in(1, 16'h8000, 0, 1, 1, 3'd0); tick();
    i_clr_sticky = 0; set_in(0, 0, 0, 0, 0, 0);
    n_checks++; if (o_sticky_ovf !== 1'b1 || o_ovf_count !== 8'd1) begin n_fail++; $display("FAIL ovf_clr_push got %b/%0d want 1/1", o_sticky_ovf, o_ovf_count); end
    tick();
  endtask

  task automatic test_saturation_reset();
    i_out_ready = 1;
    for (int i = 0; i < 260; i++) begin set_in(1, 16'(i), 0, 1, 0, 3'd7); tick(); end
    set_in(0, 0, 0, 0, 0, 0); tick();
    n_checks++; if (o_ovf_count !== 8'd255 || o_sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_count got %0d/%b want 255/1", o_ovf_count, o_sticky_ovf); end
    i_out_ready = 0;
    set_in(1, 16'hAAAA, 0, 0, 0, 3'd1); tick();
    set_in(1, 16'h5555, 0, 0, 0, 3'd2); tick(); set_in(0, 0, 0, 0, 0, 0);
    n_checks++; if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin n_fail++; $display("FAIL prerst_full got v=%b rdy=%b want 1/0", o_out_valid, o_in_ready); end
    i_rst = 1; tick();
    n_checks++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b0 || o_ovf_count !== 8'd0) begin n_fail++; $display("FAIL midrst got v=%b rdy=%b cnt=%0d want 0/0/0", o_out_valid, o_in_ready, o_ovf_count); end
    i_rst = 0; tick();
    n_checks++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin n_fail++; $display("FAIL postrst got rdy=%b v=%b want 1/0", o_in_ready, o_out_valid); end
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 2) != 0,
             ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom));
      i_out_ready  = $urandom_range(0, 2) != 0;
      i_clr_sticky = $urandom_range(0, 30) == 0;
      tick();
      h = head();
      n_checks++;
      if (o_out_valid !== (q.size() > 0) || o_in_ready !== m_ready ||
          o_out_result !== h.r || o_out_flags !== h.f || o_out_aluop !== h.op) begin
        n_fail++;
        $display("FAIL rand_fifo cyc %0d got v=%b rdy=%b %h/%b/%b want v=%b rdy=%b %h/%b/%b", i,
                 o_out_valid, o_in_ready, o_out_result, o_out_flags, o_out_aluop,
                 q.size() > 0, m_ready, h.r, h.f, h.op);
      end
      n_checks++;
      if (o_sticky_ovf !== m_sticky || o_ovf_count !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL rand_status cyc %0d got %b/%0d want %b/%0d", i, o_sticky_ovf, o_ovf_count, m_sticky, m_cnt);
      end
    end
    set_in(0, 0, 0, 0, 0, 0); i_out_ready = 0; i_clr_sticky = 0;
  endtask

  initial begin
    q.delete(); m_last = '0; m_ready = 0; m_sticky = 0; m_cnt = 0;
    test_reset();
    test_single_push();
    test_fill();
    test_streaming();
    test_overflow();
    test_saturation_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
